// File: rtl/led_matrix_scanner_pkg.sv
// Shared definitions for the 6x6 LED matrix scanner and the image generators.
package led_matrix_scanner_pkg;

    localparam int MATRIX_ROWS = 6;
    localparam int MATRIX_COLS = 6;

    // Pin polarities: rows source current when high, columns sink when low.
    localparam logic ROW_ON = 1'b1;
    localparam logic COL_ON = 1'b0;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Bit position of pixel (r,c) in the flat image; column 0 is the MSB of its row slice.
    function automatic int pixel_index(input int r, input int c);
        return MATRIX_COLS * r + (MATRIX_COLS - 1) - c;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_timer.sv
// Row scan sequencer: alternates BLANK and DRIVE phases and steps the row index.
module led_scan_timer
    import led_matrix_scanner_pkg::*;
#(
    parameter int DWELL_CYCLES = 2048,
    parameter int BLANK_CYCLES = 16,
    parameter int ROWS         = 6,
    localparam int DW          = $clog2(DWELL_CYCLES),
    localparam int IW          = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx,
    output logic          drive_en,
    output logic [DW-1:0] dwell_cnt,
    output logic          wrap
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    scan_state_t   state, state_nxt;
    logic [BW-1:0] blank_cnt, blank_cnt_nxt;
    logic [DW-1:0] dwell_cnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic          wrap_nxt;

    assign drive_en = (state == ST_DRIVE);

    // State, counters and row index; wrap is high for the first BLANK cycle after row ROWS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_BLANK;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            idx       <= '0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_cnt_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            idx       <= idx_nxt;
            wrap      <= wrap_nxt;
        end
    end

    // Phase sequencing: BLANK for BLANK_CYCLES, then DRIVE for DWELL_CYCLES on the same row.
    always_comb begin
        state_nxt     = state;
        blank_cnt_nxt = blank_cnt;
        dwell_cnt_nxt = dwell_cnt;
        idx_nxt       = idx;
        wrap_nxt      = 1'b0;
        case (state)
            ST_BLANK: begin
                if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
                    blank_cnt_nxt = '0;
                    state_nxt     = ST_DRIVE;
                end else begin
                    blank_cnt_nxt = blank_cnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
                    dwell_cnt_nxt = '0;
                    state_nxt     = ST_BLANK;
                    if (idx == IW'(ROWS - 1)) begin
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    dwell_cnt_nxt = dwell_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// 6x6 LED matrix driver: double-buffered image, row scan with blanking, 4-bit global PWM.
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int DWELL_CYCLES = 2048,
    parameter int BLANK_CYCLES = 16,
    parameter int ROWS         = MATRIX_ROWS,
    parameter int COLS         = MATRIX_COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS*COLS-1:0] img,
    input  logic                 img_valid,
    input  logic [3:0]           brightness,
    output logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    output logic                 frame_start,
    output logic                 pending
);

    localparam int DW   = $clog2(DWELL_CYCLES);
    localparam int IW   = $clog2(ROWS);
    localparam int TW   = DW + 1;
    localparam int SLOT = DWELL_CYCLES / 16;

    logic [IW-1:0]        idx;
    logic                 drive_en;
    logic [DW-1:0]        dwell_cnt;
    logic                 wrap;

    logic [ROWS*COLS-1:0] active_buf, pend_buf;
    logic [3:0]           bright_lat, bright_eff;
    logic [TW-1:0]        thresh;
    logic [COLS-1:0]      slice [ROWS];
    logic [COLS-1:0]      row_bits, col_nxt;
    logic [ROWS-1:0]      row_nxt;

    led_scan_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .ROWS         (ROWS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .drive_en  (drive_en),
        .dwell_cnt (dwell_cnt),
        .wrap      (wrap)
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_slice
        assign slice[r] = active_buf[pixel_index(r, 0) -: COLS];
    end

    // Pin values for the current FSM state; the latch is bypassed on the first DRIVE cycle
    // so a row's PWM uses the brightness sampled at its start.
    always_comb begin
        bright_eff = (dwell_cnt == '0) ? brightness : bright_lat;
        thresh     = TW'(bright_eff) * TW'(SLOT);
        row_bits   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (idx == IW'(r)) row_bits = slice[r];
            row_nxt[r] = (drive_en && idx == IW'(r)) ? ROW_ON : ~ROW_ON;
        end
        for (int c = 0; c < COLS; c++) begin
            col_nxt[c] = (drive_en && row_bits[COLS-1-c] && ({1'b0, dwell_cnt} < thresh))
                         ? COL_ON : ~COL_ON;
        end
    end

    // Buffers, brightness latch and registered pins; active only changes on the frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_buf  <= '0;
            pend_buf    <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            bright_lat  <= '0;
            row         <= '0;
            col         <= '1;
        end else begin
            frame_start <= 1'b0;
            if (wrap && img_valid) begin
                active_buf  <= img;
                pending     <= 1'b0;
                frame_start <= 1'b1;
            end else if (wrap && pending) begin
                active_buf  <= pend_buf;
                pending     <= 1'b0;
                frame_start <= 1'b1;
            end else if (img_valid) begin
                pend_buf <= img;
                pending  <= 1'b1;
            end
            if (drive_en && dwell_cnt == '0) bright_lat <= brightness;
            row <= row_nxt;
            col <= col_nxt;
        end
    end

endmodule
